mat_psum_acc: RTL

//  Receive side of the PE multiplier datapath: drains signed 16b products from MATbooth8 and accumulates
//  a programmable number of them into one partial sum. Hands the psum downstream with valid/ready.

---
 rtl/mat_psum_acc_pkg.sv | 41 ++++
 rtl/mat_psum_acc_addsat.sv | 34 +++
 rtl/mat_psum_acc.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mat_psum_acc_pkg.sv
// rtl/mat_psum_acc_pkg.sv - shared PE control types for the psum accumulator
// Contents:
//   modeT       multiplier lane mode (M8/M4/M2/XNOR)
//   numT        operand number type (unsigned/signed)
//   AuCtl       per-psum control word: mode, input and weight number types
//   psumStateT  accumulator FSM states
//   XNOR_LANES  bit matches per XNOR product, used in the +/-1 correction
package mat_psum_acc_pkg;

    typedef enum logic [1:0] {
        MODE_M8   = 2'd0,
        MODE_M4   = 2'd1,
        MODE_M2   = 2'd2,
        MODE_XNOR = 2'd3
    } modeT;

    typedef enum logic {
        NUM_UNSIGNED = 1'b0,
        NUM_SIGNED   = 1'b1
    } numT;

    typedef struct packed {
        modeT mode;
        numT  iNumT;
        numT  wNumT;
    } AuCtl;

    typedef enum logic [1:0] {
        PS_IDLE = 2'd0,
        PS_ACC  = 2'd1,
        PS_DONE = 2'd2
    } psumStateT;

    localparam int XNOR_LANES = 8;

    // Products are only non-negative when both operands are unsigned.
    function automatic logic is_unsigned_pair(input AuCtl c);
        return (c.iNumT == NUM_UNSIGNED) && (c.wNumT == NUM_UNSIGNED);
    endfunction

endpackage

// File: rtl/mat_psum_acc_addsat.sv
// rtl/mat_psum_acc_addsat.sv - signed ACC_DW adder with overflow flag and optional clamp
// Optional feature macro: PSUM_SAT_EN (clamp on overflow instead of wrapping)
// Ports:
//   a_i, b_i  in   ACC_DW  signed operands
//   sum_o     out  ACC_DW  a+b, wrapped or clamped
//   ovf_o     out  1       true result lies outside signed ACC_DW range
module psum_addsat #(
    parameter int ACC_DW = 24
) (
    input  logic [ACC_DW-1:0] a_i,
    input  logic [ACC_DW-1:0] b_i,
    output logic [ACC_DW-1:0] sum_o,
    output logic              ovf_o
);

    logic [ACC_DW-1:0] raw;

    assign raw   = a_i + b_i;
    // Overflow is only possible when both operands share a sign and the result flips it.
    assign ovf_o = (a_i[ACC_DW-1] == b_i[ACC_DW-1]) && (raw[ACC_DW-1] != a_i[ACC_DW-1]);

`ifdef PSUM_SAT_EN
    always_comb begin
        sum_o = raw;
        if (ovf_o) begin
            sum_o = a_i[ACC_DW-1] ? {1'b1, {(ACC_DW-1){1'b0}}}
                                  : {1'b0, {(ACC_DW-1){1'b1}}};
        end
    end
`else
    assign sum_o = raw;
`endif

endmodule

// File: rtl/mat_psum_acc.sv
// rtl/mat_psum_acc.sv - accumulates a programmable number of lane products into one psum
// Optional feature macro: PSUM_SAT_EN (saturating accumulate and XNOR correction)
// Ports:
//   i_clk, i_rst           clock, asynchronous active-low reset
//   i_ctl                  mode / number types, sampled at i_start
//   i_start                begin a new psum (only honoured when idle)
//   i_len                  products per psum, 0 treated as 1, sampled at i_start
//   i_prod, i_prod_valid   signed 16b product stream in
//   o_prod_ready           product accepted on valid&ready
//   o_psum, o_psum_valid   finished psum, held until i_psum_ready
//   i_psum_ready           downstream ready
//   o_busy                 not idle
//   o_ovf                  sticky overflow for the current psum
module mat_psum_acc
    import mat_psum_acc_pkg::*;
#(
    parameter int ACC_DW = 24,
    parameter int CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  AuCtl              i_ctl,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_len,
    input  logic [15:0]       i_prod,
    input  logic              i_prod_valid,
    output logic              o_prod_ready,
    output logic [ACC_DW-1:0] o_psum,
    output logic              o_psum_valid,
    input  logic              i_psum_ready,
    output logic              o_busy,
    output logic              o_ovf
);

    psumStateT         state_q;
    AuCtl              ctl_q;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ACC_DW-1:0] acc_q;
    logic [ACC_DW-1:0] psum_q;
    logic              psum_valid_q;
    logic              prod_ready_q;
    logic              busy_q;
    logic              ovf_q;

    logic [ACC_DW-1:0] prod_ext;
    logic [ACC_DW-1:0] acc_d;
    logic              add_ovf;
    logic [ACC_DW-1:0] dbl_sum;
    logic              dbl_ovf;
    logic [ACC_DW-1:0] corr_neg;
    logic [ACC_DW-1:0] xnor_sum;
    logic              xnor_ovf;
    logic              is_xnor;
    logic [ACC_DW-1:0] psum_d;
    logic              fin_ovf;
    logic              last_prod;

    // Unsigned x unsigned products reach 65025 and must not be sign-extended.
    assign prod_ext = is_unsigned_pair(ctl_q) ? ACC_DW'(i_prod)
                                              : ACC_DW'($signed(i_prod));

    psum_addsat #(.ACC_DW(ACC_DW)) u_acc_add (
        .a_i   (acc_q),
        .b_i   (prod_ext),
        .sum_o (acc_d),
        .ovf_o (add_ovf)
    );

    // XNOR lanes deliver bit-match counts; 2*acc - 8*len maps them to a +/-1 dot product.
    // Built on the post-add accumulator so the result is ready on the last handshake.
    psum_addsat #(.ACC_DW(ACC_DW)) u_xnor_dbl (
        .a_i   (acc_d),
        .b_i   (acc_d),
        .sum_o (dbl_sum),
        .ovf_o (dbl_ovf)
    );

    assign corr_neg = '0 - (ACC_DW'(len_q) * ACC_DW'(XNOR_LANES));

    psum_addsat #(.ACC_DW(ACC_DW)) u_xnor_sub (
        .a_i   (dbl_sum),
        .b_i   (corr_neg),
        .sum_o (xnor_sum),
        .ovf_o (xnor_ovf)
    );

    assign is_xnor   = (ctl_q.mode == MODE_XNOR);
    assign psum_d    = is_xnor ? xnor_sum : acc_d;
    assign fin_ovf   = is_xnor && (dbl_ovf || xnor_ovf);
    assign last_prod = (cnt_q == (len_q - 1'b1));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= PS_IDLE;
            ctl_q        <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            psum_q       <= '0;
            psum_valid_q <= 1'b0;
            prod_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            case (state_q)
                PS_IDLE: begin
                    if (i_start) begin
                        ctl_q        <= i_ctl;
                        len_q        <= (i_len == '0) ? CNT_W'(1) : i_len;
                        cnt_q        <= '0;
                        acc_q        <= '0;
                        ovf_q        <= 1'b0;
                        prod_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= PS_ACC;
                    end
                end
                PS_ACC: begin
                    if (i_prod_valid && prod_ready_q) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_prod) begin
                            psum_q       <= psum_d;
                            psum_valid_q <= 1'b1;
                            prod_ready_q <= 1'b0;
                            ovf_q        <= ovf_q | add_ovf | fin_ovf;
                            state_q      <= PS_DONE;
                        end else begin
                            ovf_q <= ovf_q | add_ovf;
                        end
                    end
                end
                PS_DONE: begin
                    if (i_psum_ready) begin
                        psum_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= PS_IDLE;
                    end
                end
                default: begin
                    psum_valid_q <= 1'b0;
                    prod_ready_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= PS_IDLE;
                end
            endcase
        end
    end

    assign o_prod_ready = prod_ready_q;
    assign o_psum       = psum_q;
    assign o_psum_valid = psum_valid_q;
    assign o_busy       = busy_q;
    assign o_ovf        = ovf_q;

endmodule
